// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage pipeline register with a
// valid/ready handshake, a synchronous flush and a saturating kill counter.
// Build option: define PIPE_STAGE_SKID_EN to add a skid entry.
// The skid entry makes in_ready a flop output, so there is no combinational
// path from out_ready to in_ready.
// Control bits are held at zero for any invalid entry.
// Payload registers only load real entries and are never cleared by flush.
module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  kill_count
);
    // Main (output-facing) entry
    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_kill;

    logic              w_in_xfer;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_in_ctrl_m;
    logic [1:0]        w_kill_n;
    logic [CNT_W+1:0]  w_kill_sum;

    // A bubble loads zero control so that out_ctrl tracks out_valid.
    assign w_in_ctrl_m = in_valid ? in_ctrl : '0;
    assign w_in_xfer   = in_valid && in_ready;

`ifdef PIPE_STAGE_SKID_EN
    logic              r_skid_valid;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;

    assign w_skid_valid = r_skid_valid;
    // Ready depends only on the skid flop, never on out_ready.
    assign in_ready     = !r_skid_valid;

    // EMPTY/BUSY/FULL are encoded by {r_skid_valid, r_valid}.
    // Main and skid updates: flush, skid-to-main refill, main load, or skid capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            r_data       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
            r_skid_data  <= '0;
        end else if (flush) begin
            r_valid      <= 1'b0;
            r_ctrl       <= '0;
            r_skid_valid <= 1'b0;
            r_skid_ctrl  <= '0;
        end else if (r_skid_valid) begin
            // FULL: main is valid, so out_ready alone means a transfer out.
            if (out_ready) begin
                r_valid      <= 1'b1;
                r_ctrl       <= r_skid_ctrl;
                r_data       <= r_skid_data;
                r_skid_valid <= 1'b0;
                r_skid_ctrl  <= '0;
            end
        end else if (!r_valid || out_ready) begin
            // EMPTY, or BUSY draining: main reloads (possibly with a bubble).
            r_valid <= in_valid;
            r_ctrl  <= w_in_ctrl_m;
            if (in_valid) begin
                r_data <= in_data;
            end
        end else if (in_valid) begin
            // BUSY and stalled: the incoming entry parks in skid.
            r_skid_valid <= 1'b1;
            r_skid_ctrl  <= in_ctrl;
            r_skid_data  <= in_data;
        end
    end
`else
    assign w_skid_valid = 1'b0;
    // Accept whenever the held entry is gone or is leaving this cycle.
    assign in_ready     = !r_valid || out_ready;

    // Main entry update: flush kills it, otherwise it loads whenever ready.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
        end else if (in_ready) begin
            r_valid <= in_valid;
            r_ctrl  <= w_in_ctrl_m;
            if (in_valid) begin
                r_data <= in_data;
            end
        end
    end
`endif

    // Entries discarded by a flush: held main, held skid, and the one arriving.
    assign w_kill_n   = {1'b0, r_valid} + {1'b0, w_skid_valid} + {1'b0, w_in_xfer};
    assign w_kill_sum = {2'b00, r_kill} + {{CNT_W{1'b0}}, w_kill_n};

    // Saturating kill counter; only reset clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_kill <= '0;
        end else if (flush) begin
            if (w_kill_sum[CNT_W+1:CNT_W] != 2'b00) begin
                r_kill <= '1;
            end else begin
                r_kill <= w_kill_sum[CNT_W-1:0];
            end
        end
    end

    assign out_valid  = r_valid;
    assign out_ctrl   = r_ctrl;
    assign out_data   = r_data;
    assign kill_count = r_kill;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// Expectations follow the PIPE_STAGE_SKID_EN build choice where they differ.
module tb_pipe_stage_reg;
    logic        clock;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_ctrl;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_ctrl;
    logic [31:0] out_data;
    logic [15:0] kill_count;

    // Narrow-counter instance used for the saturation test
    logic        s_flush;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [4:0]  s_in_ctrl;
    logic [7:0]  s_in_data;
    logic        s_out_valid;
    logic        s_out_ready;
    logic [4:0]  s_out_ctrl;
    logic [7:0]  s_out_data;
    logic [3:0]  s_kill_count;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_reg #(.DATA_W(32), .CTRL_W(5), .CNT_W(16)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .kill_count (kill_count)
    );

    pipe_stage_reg #(.DATA_W(8), .CTRL_W(5), .CNT_W(4)) u_sat (
        .clock      (clock),
        .reset      (reset),
        .flush      (s_flush),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .in_ctrl    (s_in_ctrl),
        .in_data    (s_in_data),
        .out_valid  (s_out_valid),
        .out_ready  (s_out_ready),
        .out_ctrl   (s_out_ctrl),
        .out_data   (s_out_data),
        .kill_count (s_kill_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One transaction: drive inputs, check in_ready before the edge,
    // then check the registered outputs just after it.
    task automatic cyc(input logic fl, input logic iv, input logic [4:0] ic,
                       input logic [31:0] id, input logic ordy, input logic e_rdy,
                       input logic e_v, input logic [4:0] e_c, input logic [31:0] e_d);
        flush     = fl;
        in_valid  = iv;
        in_ctrl   = ic;
        in_data   = id;
        out_ready = ordy;
        #2;
        check_eq("in_ready", in_ready, e_rdy);
        @(posedge clock);
        #1;
        check_eq("out_valid", out_valid, e_v);
        check_eq("out_ctrl", out_ctrl, e_c);
        check_eq("out_data", out_data, e_d);
        $display("t=%0t flush=%0b in=%0b/%0h/%0h ordy=%0b -> out=%0b/%0h/%0h kill=%0d",
                 $time, fl, iv, ic, id, ordy, out_valid, out_ctrl, out_data, kill_count);
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        s_flush = 1'b0; s_in_valid = 1'b0; s_in_ctrl = 5'h3; s_in_data = 8'h5A; s_out_ready = 1'b0;

        // Reset values
        #2;
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_out_ctrl", out_ctrl, 5'h0);
        check_eq("rst_out_data", out_data, 32'h0);
        check_eq("rst_kill", kill_count, 16'h0);
        check_eq("rst_in_ready", in_ready, 1'b1);
        #6 reset = 1'b1;
        @(posedge clock);
        #1;

        // Streaming: one entry per cycle, visible after the accepting edge
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 5'h1F, 32'(i), 1'b1, 1'b1, 1'b1, 5'h1F, 32'(i));
        end

        // Bubble: control zeroed, payload held
        cyc(1'b0, 1'b0, 5'h1F, 32'hABCD, 1'b1, 1'b1, 1'b0, 5'h0, 32'h8);
        check_eq("kill_after_stream", kill_count, 16'h0);

        // Backpressure for three edges, then release
`ifdef PIPE_STAGE_SKID_EN
        cyc(1'b0, 1'b1, 5'h10, 32'h10, 1'b0, 1'b1, 1'b1, 5'h10, 32'h10);
        cyc(1'b0, 1'b1, 5'h11, 32'h11, 1'b0, 1'b1, 1'b1, 5'h10, 32'h10);
        cyc(1'b0, 1'b1, 5'h12, 32'h12, 1'b0, 1'b0, 1'b1, 5'h10, 32'h10);
        cyc(1'b0, 1'b1, 5'h12, 32'h12, 1'b1, 1'b0, 1'b1, 5'h11, 32'h11);
        cyc(1'b0, 1'b1, 5'h12, 32'h12, 1'b1, 1'b1, 1'b1, 5'h12, 32'h12);
`else
        cyc(1'b0, 1'b1, 5'h10, 32'h10, 1'b0, 1'b1, 1'b1, 5'h10, 32'h10);
        cyc(1'b0, 1'b1, 5'h11, 32'h11, 1'b0, 1'b0, 1'b1, 5'h10, 32'h10);
        cyc(1'b0, 1'b1, 5'h11, 32'h11, 1'b0, 1'b0, 1'b1, 5'h10, 32'h10);
        cyc(1'b0, 1'b1, 5'h11, 32'h11, 1'b1, 1'b1, 1'b1, 5'h11, 32'h11);
        cyc(1'b0, 1'b1, 5'h12, 32'h12, 1'b1, 1'b1, 1'b1, 5'h12, 32'h12);
`endif
        cyc(1'b0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'h0, 32'h12);

        // Flush with the stage full and an entry arriving: two entries killed
`ifdef PIPE_STAGE_SKID_EN
        cyc(1'b0, 1'b1, 5'h5, 32'h20, 1'b0, 1'b1, 1'b1, 5'h5, 32'h20);
        cyc(1'b0, 1'b1, 5'h6, 32'h21, 1'b0, 1'b1, 1'b1, 5'h5, 32'h20);
        cyc(1'b1, 1'b1, 5'h7, 32'h22, 1'b0, 1'b0, 1'b0, 5'h0, 32'h20);
`else
        cyc(1'b0, 1'b1, 5'h5, 32'h20, 1'b0, 1'b1, 1'b1, 5'h5, 32'h20);
        cyc(1'b1, 1'b1, 5'h7, 32'h22, 1'b1, 1'b1, 1'b0, 5'h0, 32'h20);
`endif
        check_eq("kill_after_flush", kill_count, 16'h2);

        // Flush of an empty stage changes nothing
        cyc(1'b1, 1'b0, 5'h0, 32'h0, 1'b1, 1'b1, 1'b0, 5'h0, 32'h20);
        check_eq("kill_empty_flush", kill_count, 16'h2);

        // Traffic resumes after a flush
        cyc(1'b0, 1'b1, 5'h3, 32'h30, 1'b1, 1'b1, 1'b1, 5'h3, 32'h30);
        cyc(1'b0, 1'b1, 5'h4, 32'h40, 1'b1, 1'b1, 1'b1, 5'h4, 32'h40);

        // Asynchronous reset mid-stream, checked before the next edge
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1 reset = 1'b0;
        #1;
        check_eq("async_out_valid", out_valid, 1'b0);
        check_eq("async_out_ctrl", out_ctrl, 5'h0);
        check_eq("async_out_data", out_data, 32'h0);
        check_eq("async_kill", kill_count, 16'h0);
        check_eq("async_in_ready", in_ready, 1'b1);
        $display("t=%0t async reset -> out=%0b/%0h/%0h kill=%0d", $time, out_valid, out_ctrl, out_data, kill_count);
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        // Saturation: 20 flushes of one entry each on a 4-bit counter
        for (int i = 0; i < 20; i++) begin
            s_flush     = 1'b0;
            s_in_valid  = 1'b1;
            s_out_ready = 1'b0;
            @(posedge clock);
            #1;
            s_flush    = 1'b1;
            s_in_valid = 1'b0;
            @(posedge clock);
            #1;
            check_eq("sat_kill", s_kill_count, (i + 1 > 15) ? 64'hF : 64'(i + 1));
            $display("t=%0t sat flush %0d -> kill=%0h out_valid=%0b", $time, i, s_kill_count, s_out_valid);
        end
        s_flush = 1'b0;
        check_eq("sat_out_valid", s_out_valid, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

- Parametrised pipeline stage register that replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake, a synchronous flush that kills in-flight entries, and a saturating kill counter for debug.
- Sits between any two processor pipeline stages. Upstream drives `in_*`; downstream consumes `out_*`.

## Interface
- `DATA_W`, default 32: width of the payload. Payload is not cleared on bubble or flush.
- `CTRL_W`, default 5: width of the control field. It is forced to zero whenever the entry is invalid.
- `CNT_W`, default 16: width of the kill counter.

Ports (name, direction, width, meaning):
- `clock`, in, 1: clock, rising edge.
- `reset`, in, 1: reset, asynchronous, active-low.
- `flush`, in, 1: synchronous kill of all held and incoming entries.
- `in_valid`, in, 1: upstream entry present.
- `in_ready`, out, 1: stage accepts an entry this cycle.
- `in_ctrl`, in, `CTRL_W`: upstream control bits.
- `in_data`, in, `DATA_W`: upstream payload.
- `out_valid`, out, 1: entry presented downstream.
- `out_ready`, in, 1: downstream accepts.
- `out_ctrl`, out, `CTRL_W`: control bits. Zero whenever `out_valid` = 0.
- `out_data`, out, `DATA_W`: payload.
- `kill_count`, out, `CNT_W`: saturating count of valid entries discarded by flush.

## Operation
- **Transfers.** A transfer in occurs when `in_valid` && `in_ready` at a rising edge. A transfer out occurs when `out_valid` && `out_ready` at a rising edge.
- **Flush priority.** Flush overrides every transfer.
  - At the edge, all entries become invalid, and `out_ctrl` and the skid control bits go to 0.
  - Payload registers hold their values.
- **Flush accounting.** `kill_count` increments by the number of valid entries discarded at a flush edge: held main entry + held skid entry + the incoming entry if a transfer in occurs that cycle.
  - It saturates at all-ones and never wraps.
  - Only reset clears it.
- **Bubble.** When the main register loads with `in_valid` = 0, it sets `out_valid` = 0 and `out_ctrl` = 0. `out_data` retains its old value.
- **Ordering.** Entries leave in arrival order. None is duplicated or dropped except by flush.

## Timing
- Reset values: `out_valid` 0, `out_ctrl` 0, `out_data` 0, `kill_count` 0, skid empty, `in_ready` 1.
- Latency is 1 cycle: an entry accepted at edge N is visible on `out_*` after edge N.
- **Without skid:**
  - `in_ready` = !`out_valid` || `out_ready`. This is a combinational path from `out_ready`.
  - Full throughput is one entry per cycle.
- **With skid:**
  - `in_ready` = !`skid_valid`. It is registered, with no combinational path from `out_ready`.
  - Full throughput is one entry per cycle.
- Skid states:
  - EMPTY: main invalid. A transfer in goes to BUSY.
  - BUSY: main valid, skid empty.
    - Transfer in and transfer out: stays BUSY, main reloads.
    - Transfer out only: goes to EMPTY.
    - Transfer in without transfer out: goes to FULL, with the entry stored in skid.
  - FULL: `in_ready` = 0. A transfer out moves skid to main and goes to BUSY.
  - Flush from any state goes to EMPTY.
- Reset asserted mid-operation clears immediately and asynchronously. Entries are lost and are not counted.
- A flush with no valid entries leaves `kill_count` unchanged.

## Configuration
- `PIPE_STAGE_SKID_EN`:
  - Defined: a second entry register (skid) is compiled in, and `in_ready` is registered as above.
  - Undefined: single register, combinational `in_ready`, no skid state. Maximum kill per flush is 2 in both builds.

## Test plan
- **Reset:** assert `reset` = 0 mid-stream with `out_valid` = 1 → outputs go to reset values without waiting for an edge; `in_ready` = 1.
- **Streaming:** `out_ready` held 1, send `in_data` 0x1..0x8 with `in_ctrl` 5'h1F on consecutive cycles → outputs appear one cycle later in order, one per cycle.
- **Backpressure:** hold `out_ready` = 0 for 3 cycles while `in_valid` = 1.
  - Without skid: `in_ready` falls in the same cycle the stage fills.
  - With skid: exactly one extra entry is accepted, then `in_ready` = 0.
  - On release, no loss or duplication.
- **Flush:** stage full (skid build: main and skid full) plus `in_valid` = 1, assert `flush` one cycle → `out_valid` = 0 and `out_ctrl` = 0 next cycle; `out_data` unchanged; `kill_count` += 2.
- **Saturation:** with `CNT_W` = 4, do 20 flushes each killing one entry → `kill_count` stops at 4'hF.
- **Bubble:** `in_valid` = 0 with `in_ctrl` = 5'h1F and `in_data` = 0xABCD → `out_ctrl` = 0, `out_valid` = 0, `out_data` holds its previous value.
